// File: rtl/cache_line_fill_unit_if.sv
// Signal bundle between the line fill unit, cache_memory port 0 and the next memory level.
interface cache_line_fill_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OFFSET_BITS    = 2,
  parameter int INDEX_BITS     = 8,
  parameter int ADDRESS_BITS   = 32,
  parameter int WAY_BITS       = 2,
  parameter int STATUS_BITS    = 2,
  parameter int COHERENCE_BITS = 2
) ();
  localparam int BLOCK_WIDTH = DATA_WIDTH * (2 ** OFFSET_BITS);
  localparam int TAG_BITS    = ADDRESS_BITS - OFFSET_BITS - INDEX_BITS;

  logic                                miss_start;
  logic [INDEX_BITS-1:0]               miss_index;
  logic [TAG_BITS-1:0]                 miss_tag;
  logic                                miss_write;
  logic [OFFSET_BITS-1:0]              miss_word;
  logic [DATA_WIDTH-1:0]               miss_wdata;
  logic [COHERENCE_BITS-1:0]           fill_coh;
  logic [WAY_BITS-1:0]                 victim_way;
  logic [TAG_BITS-1:0]                 victim_tag;
  logic [STATUS_BITS-1:0]              victim_status;
  logic [BLOCK_WIDTH-1:0]              victim_data;
  logic                                mem_req_valid;
  logic                                mem_req_ready;
  logic                                mem_req_write;
  logic [ADDRESS_BITS-1:0]             mem_req_addr;
  logic [BLOCK_WIDTH-1:0]              mem_req_data;
  logic                                mem_resp_valid;
  logic [BLOCK_WIDTH-1:0]              mem_resp_data;
  logic                                cache_write;
  logic [WAY_BITS-1:0]                 cache_way;
  logic [INDEX_BITS-1:0]               cache_index;
  logic [TAG_BITS-1:0]                 cache_tag;
  logic [STATUS_BITS+COHERENCE_BITS-1:0] cache_meta;
  logic [BLOCK_WIDTH-1:0]              cache_data;
  logic                                busy;
  logic                                done;

  modport slave (
    input  miss_start, miss_index, miss_tag, miss_write, miss_word, miss_wdata, fill_coh,
    input  victim_way, victim_tag, victim_status, victim_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    output cache_write, cache_way, cache_index, cache_tag, cache_meta, cache_data,
    output busy, done
  );

  modport master (
    output miss_start, miss_index, miss_tag, miss_write, miss_word, miss_wdata, fill_coh,
    output victim_way, victim_tag, victim_status, victim_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    input  cache_write, cache_way, cache_index, cache_tag, cache_meta, cache_data,
    input  busy, done
  );
endinterface

// File: rtl/cache_line_fill_unit.sv
// Miss handler behind cache_memory port 0: optional dirty-victim writeback, line fill,
// store-word merge and a single-cycle install of the new line.
module cache_line_fill_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int OFFSET_BITS    = 2,
  parameter int INDEX_BITS     = 8,
  parameter int ADDRESS_BITS   = 32,
  parameter int WAY_BITS       = 2,
  parameter int STATUS_BITS    = 2,
  parameter int COHERENCE_BITS = 2
) (
  input logic                   clock,
  input logic                   reset,
  cache_line_fill_unit_if.slave bus
);
  localparam int WORDS       = 2 ** OFFSET_BITS;
  localparam int BLOCK_WIDTH = DATA_WIDTH * WORDS;
  localparam int TAG_BITS    = ADDRESS_BITS - OFFSET_BITS - INDEX_BITS;

  // state      | meaning
  // S_IDLE     | waiting for miss_start
  // S_WB_REQ   | writing the dirty victim line to memory
  // S_FILL_REQ | requesting the missing line
  // S_FILL_WAIT| waiting for fill data
  // S_UPDATE   | installing the line into cache_memory, done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_UPDATE
  } state_e;

  state_e                    state_q, state_d;
  logic [INDEX_BITS-1:0]     index_q, index_d;
  logic [TAG_BITS-1:0]       tag_q, tag_d;
  logic                      write_q, write_d;
  logic [OFFSET_BITS-1:0]    word_q, word_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [COHERENCE_BITS-1:0] coh_q, coh_d;
  logic [WAY_BITS-1:0]       way_q, way_d;
  logic [TAG_BITS-1:0]       vtag_q, vtag_d;
  logic [BLOCK_WIDTH-1:0]    vdata_q, vdata_d;
  logic [BLOCK_WIDTH-1:0]    fill_q, fill_d;

  logic                      victim_dirty;
  logic [BLOCK_WIDTH-1:0]    merged;
  logic [STATUS_BITS-1:0]    new_status;

  assign victim_dirty = bus.victim_status[STATUS_BITS-1] & bus.victim_status[0];

  always_comb begin
    merged = fill_q;
    for (int w = 0; w < WORDS; w++) begin
      if (write_q && (word_q == w[OFFSET_BITS-1:0])) begin
        merged[w*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
      end
    end
    // A store merge leaves the freshly installed line dirty.
    new_status                = '0;
    new_status[STATUS_BITS-1] = 1'b1;
    new_status[0]             = write_q;
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    tag_d   = tag_q;
    write_d = write_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    coh_d   = coh_q;
    way_d   = way_q;
    vtag_d  = vtag_q;
    vdata_d = vdata_q;
    fill_d  = fill_q;

    bus.mem_req_valid = 1'b0;
    bus.mem_req_write = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_data  = '0;
    bus.cache_write   = 1'b0;
    bus.cache_way     = '0;
    bus.cache_index   = '0;
    bus.cache_tag     = '0;
    bus.cache_meta    = '0;
    bus.cache_data    = '0;
    bus.done          = 1'b0;
    bus.busy          = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (bus.miss_start) begin
          index_d = bus.miss_index;
          tag_d   = bus.miss_tag;
          write_d = bus.miss_write;
          word_d  = bus.miss_word;
          wdata_d = bus.miss_wdata;
          coh_d   = bus.fill_coh;
          way_d   = bus.victim_way;
          vtag_d  = bus.victim_tag;
          vdata_d = bus.victim_data;
          state_d = victim_dirty ? S_WB_REQ : S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = {vtag_q, index_q, {OFFSET_BITS{1'b0}}};
        bus.mem_req_data  = vdata_q;
        if (bus.mem_req_ready) state_d = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {tag_q, index_q, {OFFSET_BITS{1'b0}}};
        if (bus.mem_req_ready) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (bus.mem_resp_valid) begin
          fill_d  = bus.mem_resp_data;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        bus.cache_write = 1'b1;
        bus.cache_way   = way_q;
        bus.cache_index = index_q;
        bus.cache_tag   = tag_q;
        bus.cache_meta  = {new_status, coh_q};
        bus.cache_data  = merged;
        bus.done        = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      tag_q   <= '0;
      write_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      coh_q   <= '0;
      way_q   <= '0;
      vtag_q  <= '0;
      vdata_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      tag_q   <= tag_d;
      write_q <= write_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      coh_q   <= coh_d;
      way_q   <= way_d;
      vtag_q  <= vtag_d;
      vdata_q <= vdata_d;
      fill_q  <= fill_d;
    end
  end
endmodule
